// File: rtl/sprite_pkg.sv
// Arbiter-local types and defaults for the sprite controller bus.
package sprite_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // Cycles a granted transfer may wait for ack before it is aborted
  localparam logic [11:0] TIMEOUT_DEFAULT = 12'd1023;

  // Cycle id presented to the slave while no master owns the bus
  localparam logic [3:0] CID_IDLE = 4'd7;

endpackage

// File: rtl/wishbone_pkg.sv
// Wishbone B4 request/response bundles shared by the sprite subsystem.
package wishbone_pkg;

  // Burst type extension
  typedef enum logic [1:0] {
    LINEAR = 2'd0,
    WRAP4  = 2'd1,
    WRAP8  = 2'd2,
    WRAP16 = 2'd3
  } wb_bte_t;

  // Cycle type identifier
  typedef enum logic [2:0] {
    CLASSIC     = 3'd0,
    CONST_BURST = 3'd1,
    INCR_BURST  = 3'd2,
    END_BURST   = 3'd7
  } wb_cti_t;

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
    wb_bte_t     bte;
    wb_cti_t     cti;
    logic [7:0]  blen;
    logic [3:0]  cid;
  } wb_write_request32_t;

  typedef struct packed {
    logic        ack;
    logic        err;
    logic [31:0] dat;
  } wb_read_response32_t;

endpackage

// File: rtl/sprite_bus_arbiter_rr_pick.sv
// Combinational round-robin finder: first pending requester after 'last', wrapping.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] pending,
  input  logic [IW-1:0]   last,
  output logic            valid,
  output logic [IW-1:0]   idx
);

  logic [31:0] cand;

  // Scan last+1 .. last+NREQ; 'last' itself comes last so it only wins when alone.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = 1; k <= int'(NREQ); k++) begin
      cand = (32'(last) + 32'(k)) % NREQ;
      if (!valid && pending[cand[IW-1:0]]) begin
        valid = 1'b1;
        idx   = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/sprite_bus_arbiter.sv
// Round-robin Wishbone arbiter giving NREQ masters access to the sprite controller slave.
module sprite_bus_arbiter
  import wishbone_pkg::*;
  import sprite_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter logic [11:0] TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                                clk,
  input  logic                                rst,
  input  wb_write_request32_t [NREQ-1:0]      req_i,
  output wb_read_response32_t [NREQ-1:0]      resp_o,
  output wb_write_request32_t                 m_req,
  input  wb_read_response32_t                 m_resp,
  output logic                                cs,
  output logic [NREQ-1:0]                     grant_o,
  output logic                                timeout_o
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam wb_write_request32_t MReqReset = '{
    cyc:  1'b0,
    stb:  1'b0,
    we:   1'b0,
    sel:  4'h0,
    adr:  32'h0,
    dat:  32'h0,
    bte:  LINEAR,
    cti:  CLASSIC,
    blen: 8'd0,
    cid:  CID_IDLE
  };

  state_t              state_q, state_d;
  logic [IW-1:0]       last_grant_q, last_grant_d;
  logic [11:0]         cnt_q, cnt_d;
  wb_write_request32_t m_req_q, m_req_d;

  logic [NREQ-1:0]     pending;
  logic                pick_valid;
  logic [IW-1:0]       pick_idx;
  logic                abort;

  // A master is pending when it drives both cyc and stb
  always_comb begin
    pending = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      pending[i] = req_i[i].cyc & req_i[i].stb;
    end
  end

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .pending (pending),
    .last    (last_grant_q),
    .valid   (pick_valid),
    .idx     (pick_idx)
  );

  // Arbitration FSM next state; last_grant_q doubles as the current owner while BUSY.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    m_req_d      = m_req_q;
    abort        = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Never start a cycle while the slave is still holding ack from the last one
        if (pick_valid && !m_resp.ack) begin
          state_d      = BUSY;
          last_grant_d = pick_idx;
          cnt_d        = '0;
          m_req_d      = req_i[pick_idx];
        end
      end

      BUSY: begin
        // Release on ack so a master still holding cyc cannot retain the bus
        if (m_resp.ack || !req_i[last_grant_q].cyc) begin
          state_d     = RELEASE;
          m_req_d.cyc = 1'b0;
          m_req_d.stb = 1'b0;
          m_req_d.we  = 1'b0;
        end else if (cnt_q == TIMEOUT) begin
          // Reset wins over abort so a reset never emits a stray err/timeout pulse
          abort       = ~rst;
          state_d     = RELEASE;
          m_req_d.cyc = 1'b0;
          m_req_d.stb = 1'b0;
          m_req_d.we  = 1'b0;
        end else begin
          cnt_d   = cnt_q + 12'd1;
          m_req_d = req_i[last_grant_q];
        end
      end

      RELEASE: begin
        if (!m_resp.ack) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d     = IDLE;
        m_req_d.cyc = 1'b0;
        m_req_d.stb = 1'b0;
        m_req_d.we  = 1'b0;
      end
    endcase
  end

  // State, owner, timeout counter and slave-side request registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= IW'(NREQ - 1);
      cnt_q        <= '0;
      m_req_q      <= MReqReset;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      m_req_q      <= m_req_d;
    end
  end

  // Grant decode and combinational response steering to the owner only
  always_comb begin
    resp_o    = '0;
    grant_o   = '0;
    timeout_o = abort;
    if (state_q == BUSY) begin
      grant_o                    = NREQ'(1) << last_grant_q;
      resp_o[last_grant_q]       = m_resp;
      resp_o[last_grant_q].err   = m_resp.err | abort;
    end
  end

  assign m_req = m_req_q;
  assign cs    = m_req_q.cyc;

endmodule

// File: tb/tb_sprite_bus_arbiter.sv
// Directed self-checking bench for sprite_bus_arbiter (NREQ=4, TIMEOUT=16).
module tb_sprite_bus_arbiter;
  import wishbone_pkg::*;

  localparam int NREQ = 4;

  logic                                clk;
  logic                                rst;
  wb_write_request32_t [NREQ-1:0]      req;
  wb_read_response32_t [NREQ-1:0]      resp;
  wb_write_request32_t                 m_req;
  wb_read_response32_t                 m_resp;
  logic                                cs;
  logic [NREQ-1:0]                     grant_o;
  logic                                timeout_o;

  int checks = 0;
  int errors = 0;

  sprite_bus_arbiter #(
    .NREQ    (NREQ),
    .TIMEOUT (12'd16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req),
    .resp_o    (resp),
    .m_req     (m_req),
    .m_resp    (m_resp),
    .cs        (cs),
    .grant_o   (grant_o),
    .timeout_o (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    req    = '0;
    m_resp = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic apply(input logic [3:0] c, input logic [3:0] s);
    for (int i = 0; i < NREQ; i++) begin
      req[i].cyc = c[i];
      req[i].stb = s[i];
      req[i].sel = 4'hF;
      req[i].adr = 32'h100 + 32'(i) * 32'd16;
    end
  endtask

  typedef struct {
    logic [3:0] cyc;
    logic [3:0] stb;
    logic [3:0] exp_grant;
    int         exp_idx;
  } vec_t;

  localparam int NVEC = 11;
  vec_t vecs [NVEC];

  initial begin
    int w;
    int pulses;
    int err_cnt;
    int pulse_at;
    int cs_low_at;
    logic [33:0] others;

    // Requests stay asserted between vectors, so the holder competes again
    vecs[0]  = '{4'b0101, 4'b0101, 4'b0001, 0};
    vecs[1]  = '{4'b0101, 4'b0101, 4'b0100, 2};
    vecs[2]  = '{4'b0101, 4'b0101, 4'b0001, 0};
    vecs[3]  = '{4'b0101, 4'b0101, 4'b0100, 2};
    vecs[4]  = '{4'b1111, 4'b1111, 4'b1000, 3};
    vecs[5]  = '{4'b1111, 4'b1111, 4'b0001, 0};
    vecs[6]  = '{4'b0010, 4'b0010, 4'b0010, 1};
    vecs[7]  = '{4'b1010, 4'b1010, 4'b1000, 3};
    vecs[8]  = '{4'b1001, 4'b1001, 4'b0001, 0};
    vecs[9]  = '{4'b0001, 4'b0001, 4'b0001, 0};
    vecs[10] = '{4'b0110, 4'b0100, 4'b0100, 2};

    // Reset state
    do_reset();
    check("rst grant", 64'(grant_o), 64'd0);
    check("rst cs", 64'(cs), 64'd0);
    check("rst timeout", 64'(timeout_o), 64'd0);
    check("rst cyc_stb_we", 64'({m_req.cyc, m_req.stb, m_req.we}), 64'd0);
    check("rst bte", 64'(m_req.bte), 64'(LINEAR));
    check("rst cti", 64'(m_req.cti), 64'(CLASSIC));
    check("rst blen", 64'(m_req.blen), 64'd0);
    check("rst cid", 64'(m_req.cid), 64'd7);
    check("rst resp", 64'(resp), 64'd0);

    // Round-robin table
    for (int v = 0; v < NVEC; v++) begin
      apply(vecs[v].cyc, vecs[v].stb);
      w = 0;
      while (grant_o == '0 && w < 8) begin
        tick();
        w++;
      end
      check($sformatf("v%0d grant", v), 64'(grant_o), 64'(vecs[v].exp_grant));
      check($sformatf("v%0d cs", v), 64'(cs), 64'd1);
      check($sformatf("v%0d adr", v), 64'(m_req.adr),
            64'(32'h100 + 32'(vecs[v].exp_idx) * 32'd16));
      m_resp.ack = 1'b1;
      m_resp.dat = 32'hA000_0000 + 32'(v);
      #1;
      check($sformatf("v%0d ack", v), 64'(resp[vecs[v].exp_idx].ack), 64'd1);
      check($sformatf("v%0d rdat", v), 64'(resp[vecs[v].exp_idx].dat),
            64'(32'hA000_0000 + 32'(v)));
      others = '0;
      for (int i = 0; i < NREQ; i++) begin
        if (i != vecs[v].exp_idx) others = others | resp[i];
      end
      check($sformatf("v%0d others", v), 64'(others), 64'd0);
      tick();
      m_resp = '0;
    end

    // Single write from requester 1, ack three cycles in
    do_reset();
    req[1].cyc = 1'b1;
    req[1].stb = 1'b1;
    req[1].we  = 1'b1;
    req[1].sel = 4'hF;
    req[1].adr = 32'h14;
    req[1].dat = 32'h1234_5678;
    tick();
    check("w grant", 64'(grant_o), 64'b0010);
    check("w cs", 64'(cs), 64'd1);
    check("w adr", 64'(m_req.adr), 64'h14);
    check("w dat", 64'(m_req.dat), 64'h1234_5678);
    check("w we", 64'(m_req.we), 64'd1);
    req[1].adr = 32'h18;
    #1;
    check("w adr held", 64'(m_req.adr), 64'h14);
    tick();
    check("w adr track", 64'(m_req.adr), 64'h18);
    tick();
    tick();
    m_resp.ack = 1'b1;
    m_resp.dat = 32'hCAFE;
    #1;
    check("w ack", 64'(resp[1].ack), 64'd1);
    check("w other resp", 64'(resp[0]), 64'd0);
    tick();
    m_resp     = '0;
    req[1].cyc = 1'b0;
    req[1].stb = 1'b0;
    check("w release cs", 64'(cs), 64'd0);
    check("w release grant", 64'(grant_o), 64'd0);
    tick();
    req[1].cyc = 1'b1;
    req[1].stb = 1'b1;
    tick();
    check("w regrant", 64'(grant_o), 64'b0010);
    req[1].cyc = 1'b0;
    req[1].stb = 1'b0;
    tick();
    check("w cyc drop cs", 64'(cs), 64'd0);
    check("w cyc drop ack", 64'(resp[1].ack), 64'd0);

    // Slave never acks
    do_reset();
    req[0].cyc = 1'b1;
    req[0].stb = 1'b1;
    tick();
    pulses    = 0;
    err_cnt   = 0;
    pulse_at  = -1;
    cs_low_at = -1;
    for (int k = 0; k < 25; k++) begin
      if (timeout_o) begin
        pulses++;
        pulse_at = k;
      end
      if (resp[0].err) err_cnt++;
      if (!cs && cs_low_at < 0) cs_low_at = k;
      tick();
    end
    check("to pulses", 64'(pulses), 64'd1);
    check("to pulse_at", 64'(pulse_at), 64'd16);
    check("to err", 64'(err_cnt), 64'd1);
    check("to cs_low_at", 64'(cs_low_at), 64'd17);

    // Ack on the cycle the counter reaches TIMEOUT
    do_reset();
    req[2].cyc = 1'b1;
    req[2].stb = 1'b1;
    tick();
    for (int k = 0; k < 16; k++) tick();
    m_resp.ack = 1'b1;
    #1;
    check("ta grant", 64'(grant_o), 64'b0100);
    check("ta ack", 64'(resp[2].ack), 64'd1);
    check("ta err", 64'(resp[2].err), 64'd0);
    check("ta timeout", 64'(timeout_o), 64'd0);
    tick();
    m_resp = '0;
    check("ta cs", 64'(cs), 64'd0);
    check("ta timeout after", 64'(timeout_o), 64'd0);

    // Slave holds ack after the cycle ends
    do_reset();
    req[3].cyc = 1'b1;
    req[3].stb = 1'b1;
    tick();
    check("ha grant", 64'(grant_o), 64'b1000);
    m_resp.ack = 1'b1;
    tick();
    req[3] = '0;
    req[1].cyc = 1'b1;
    req[1].stb = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("ha hold%0d", k), 64'({cs, grant_o}), 64'd0);
      tick();
    end
    m_resp.ack = 1'b0;
    #1;
    check("ha low grant", 64'(grant_o), 64'd0);
    tick();
    check("ha idle grant", 64'(grant_o), 64'd0);
    tick();
    check("ha new grant", 64'(grant_o), 64'b0010);

    // Reset while BUSY
    do_reset();
    req[2].cyc = 1'b1;
    req[2].stb = 1'b1;
    tick();
    check("rb grant", 64'(grant_o), 64'b0100);
    rst = 1'b1;
    tick();
    check("rb cs", 64'(cs), 64'd0);
    check("rb grant0", 64'(grant_o), 64'd0);
    check("rb timeout", 64'(timeout_o), 64'd0);
    check("rb err", 64'(resp[2].err), 64'd0);
    rst = 1'b0;
    req[2] = '0;
    req[0].cyc = 1'b1;
    req[0].stb = 1'b1;
    req[3].cyc = 1'b1;
    req[3].stb = 1'b1;
    tick();
    check("rb next grant", 64'(grant_o), 64'b0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
